uart_ram_tx_reader: RTL and testbench
=====================================

Name: uart_ram_tx_reader

Overview:
- Reader-side companion to the UART receive buffer RAM (15-bit address, 8-bit data, unregistered read output, 1-cycle read latency).
- On a start request, fetches LEN bytes from the RAM read port beginning at BASE_ADDR and serialises each byte onto a UART TX line (8N1, LSB first).
- Sits between the buffer RAM's read port and the board TX pin; asserts busy while running and pulses done at the end.

Parameters:
ADDR_WIDTH, 15, RAM read address width
DATA_WIDTH, 8, RAM read data width; fixed at 8 for the UART frame
CLK_FREQ, 50_000_000, rd_clk frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)

Ports:
rd_clk  input  1  single clock for the block and the RAM read port
rd_rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first RAM address, latched on accepted start
len  input  ADDR_WIDTH+1  byte count, latched on accepted start; 0 allowed
rd_addr  output  ADDR_WIDTH  RAM read address (registered)
rd_data  input  DATA_WIDTH  RAM read data, valid the cycle after rd_addr is presented
tx  output  1  UART serial output, idle high
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset values: tx=1, busy=0, done=0, rd_addr=0, state=IDLE, all counters 0.
- Interface decision: one clock, rd_clk; reset rd_rst is asynchronous and active-high.
- States: IDLE, FETCH, LATCH, START, DATA, STOP, FIN.
- IDLE:
  - start=1 with len!=0: latch base_addr into rd_addr, latch len into the remaining counter, go to FETCH.
  - start=1 with len=0: go to FIN (done pulses 1 cycle later, no tx activity).
- FETCH: rd_addr is held stable; the RAM registers its output. Go to LATCH.
- LATCH: capture rd_data into the 8-bit shift register; increment rd_addr modulo 2^ADDR_WIDTH (wraps 0x7FFF -> 0x0000); decrement remaining; go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index counts the bits.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then go to FETCH if remaining!=0, otherwise go to FIN.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, go to IDLE.
- Latency:
  - Accepted start at cycle 0 -> tx falls at cycle 3.
  - Consecutive frames are separated by exactly 2 idle-high cycles (FETCH + LATCH).
- start while not IDLE is ignored; base_addr and len are don't-care after acceptance.
- The bit timer is a counter 0..CLKS_PER_BIT-1, cleared on every state entry.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), with no partial stop bit. The state machine restarts in IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame is 11 bits (8E1).
- Undefined: no parity state, 10-bit 8N1 frame. The state encoding omits PARITY.

Decomposition:
- Shared package uart_pkg:
  - state enumeration and its encoding width
  - UART_DATA_BITS=8
  - a CLKS_PER_BIT calculation function
  - TX idle level constant
- One natural sub-module: uart_tx_serializer.
  - Inputs: byte + load.
  - Outputs: tx and frame_done; owns the bit timer, bit index, and START/DATA/(PARITY)/STOP sequencing.
  - The top level keeps IDLE/FETCH/LATCH/FIN and address/length control.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10) and a behavioural model of the 1-cycle-latency RAM.
1. RAM[0x0010]=0x55, start with base_addr=0x0010, len=1 -> tx falls at cycle 3; bits 1,0,1,0,1,0,1,0 at 10 cycles each; stop high; done pulses at cycle 104; busy high on cycles 1..103.
2. RAM[0x20..0x22]=0xA5,0x00,0xFF, len=3 -> three frames decode to A5,00,FF; tx high exactly 2 cycles between each stop bit and the next start bit; rd_addr ends at 0x23.
3. base_addr=0x7FFF, len=2, RAM[0x7FFF]=0x11, RAM[0x0000]=0x22 -> bytes 0x11 then 0x22 on tx; rd_addr wraps to 0x0000 then 0x0001.
4. len=0 -> no tx transition; done pulses at cycle 2; busy high for cycle 1 only.
5. A second start pulse mid-frame -> ignored; only the original len bytes are sent; one done pulse.
6. rd_rst asserted during the DATA bits of byte 0x3C -> tx=1 immediately, busy=0, done never pulses; a fresh start afterwards transmits 0x3C correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffer-RAM UART transmit reader: the controller
// state enumeration (and its encoding width), frame constants and the
// bit-period helper.
//
// Configuration macro: UART_TX_PARITY_EN -- adds the PARITY state (8E1 frame).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TX_IDLE        = 1'b1;   // line level between frames
    localparam int   STATE_W        = 3;

    // IDLE/FETCH/LATCH/FIN are driven by the reader; START/DATA/(PARITY)/STOP
    // are the serializer's frame phases.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_FIN
    } state_e;

    // Clock cycles per UART bit (integer division; caller keeps it >= 2).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Sends one byte as a UART frame, LSB first: start bit, 8 data bits,
// optional even-parity bit (UART_TX_PARITY_EN), stop bit. Each bit lasts
// CLKS_PER_BIT cycles.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset (tx returns high at once)
//   byte_i       byte to send, captured when load_i is high in idle
//   load_i       start a frame (ignored while a frame is in progress)
//   tx_o         registered serial output, idle high
//   frame_done_o high during the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [UART_DATA_BITS-1:0] byte_i,
    input  logic                      load_i,
    output logic                      tx_o,
    output logic                      frame_done_o
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST   = 3'(UART_DATA_BITS - 1);

    state_e                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic                      tx_q, tx_d;
    logic                      timer_last;

    assign timer_last = (timer_q == TIMER_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        frame_done_o = 1'b0;
        // Every phase change happens on timer_last (or from idle, where the
        // timer is already zero), so this also clears the timer on each entry.
        timer_d      = (state_q == ST_IDLE || timer_last) ? '0 : timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d   = ST_START;
                    shift_d   = byte_i;
                    parity_d  = ^byte_i;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (timer_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (timer_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_last) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (timer_last) begin
                    state_d      = ST_IDLE;
                    frame_done_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered from the next state so it lines up with state_q.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= TX_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/uart_ram_tx_reader.sv
// -----------------------------------------------------------------------------
// uart_ram_tx_reader
// Reads len bytes from the UART buffer RAM starting at base_addr (1-cycle read
// latency) and transmits each one on tx. busy covers the whole transfer and
// done pulses for one cycle at the end.
//
// Configuration macro: UART_TX_PARITY_EN -- 8E1 frames instead of 8N1.
//
// Ports:
//   rd_clk     clock for the block and the RAM read port
//   rd_rst     asynchronous active-high reset
//   start      one-cycle request, only honoured when idle
//   base_addr  first RAM address (latched on accepted start)
//   len        byte count, 0 allowed (latched on accepted start)
//   rd_addr    registered RAM read address
//   rd_data    RAM read data, valid the cycle after rd_addr
//   tx         UART serial output, idle high
//   busy       transfer in progress
//   done       one-cycle end-of-transfer pulse
// -----------------------------------------------------------------------------
module uart_ram_tx_reader
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load;
    logic                  frame_done;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk_i        (rd_clk),
        .rst_i        (rd_rst),
        .byte_i       (rd_data[UART_DATA_BITS-1:0]),
        .load_i       (load),
        .tx_o         (tx),
        .frame_done_o (frame_done)
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len != '0) begin
                        rd_addr_d   = base_addr;
                        remaining_d = len;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            // rd_addr is stable; the RAM registers its output this cycle.
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                load        = 1'b1;
                rd_addr_d   = rd_addr_q + 1'b1;   // wraps at 2^ADDR_WIDTH
                remaining_d = remaining_q - 1'b1;
                state_d     = ST_START;
            end
            // The reader parks in START while the serializer runs the frame.
            ST_START: begin
                if (frame_done) state_d = (remaining_q != '0) ? ST_FETCH : ST_FIN;
            end
            // done and busy are registered, so both change in the next cycle.
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_uart_ram_tx_reader.sv
// -----------------------------------------------------------------------------
// tb_uart_ram_tx_reader
// Bench for uart_ram_tx_reader at CLKS_PER_BIT = 10. Expected per-cycle
// tx/busy/done/rd_addr traces are built from the frame rules; a table of
// transfers carries hand-computed end addresses and done cycles.
// -----------------------------------------------------------------------------
module tb_uart_ram_tx_reader;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        start;
    logic [14:0] base_addr;
    logic [15:0] len;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data;
    logic        tx, busy, done;

    logic [7:0]  mem [0:32767];
    logic [14:0] model_addr;
    int          vectors = 0;
    int          errors  = 0;

    typedef struct packed {
        logic        tx;
        logic        busy;
        logic        done;
        logic [14:0] addr;
    } obs_t;

    typedef struct {
        logic [14:0] base;
        logic [15:0] len;
        logic [7:0]  d0, d1, d2;
        int          glitch;     // cycle of an extra start pulse, 0 = none
        logic [14:0] exp_end;    // rd_addr after the transfer
        int          exp_done;   // cycle of the done pulse
    } vec_t;

    uart_ram_tx_reader #(
        .ADDR_WIDTH (15),
        .DATA_WIDTH (8),
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 rd_clk = ~rd_clk;

    // RAM read port with one cycle of latency.
    always @(posedge rd_clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic t, input logic b, input logic d, input logic [14:0] a);
        obs_t o;
        o.tx   = t;
        o.busy = b;
        o.done = d;
        o.addr = a;
        return o;
    endfunction

    // Line level of bit j of the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Expected done cycle from the frame arithmetic (used by the table).
    function automatic int done_at(input int n);
        if (n == 0) return 2;
        return 1 + 2 + n * FRAME_BITS * CPB + (n - 1) * 2 + 1;
    endfunction

    // Runs one transfer from an idle state, comparing every cycle with the
    // expected trace. Cycle 0 is the cycle start is asserted.
    task automatic run_xfer(input logic [14:0] base_i, input logic [15:0] len_i,
                            input int glitch_cyc, output int done_cyc);
        obs_t        exp_q[$];
        obs_t        o;
        logic [14:0] a;
        logic [7:0]  b;

        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, model_addr));
        if (len_i == 0) begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, model_addr));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, model_addr));
        end else begin
            for (int i = 0; i < int'(len_i); i++) begin
                a = base_i + 15'(i);
                b = mem[a];
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, a));  // fetch
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, a));  // latch
                for (int j = 0; j < FRAME_BITS; j++)
                    for (int c = 0; c < CPB; c++)
                        exp_q.push_back(mk(frame_bit(b, j), 1'b1, 1'b0, a + 15'd1));
            end
            model_addr = base_i + 15'(len_i);
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, model_addr));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, model_addr));
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, model_addr));

        done_cyc = -1;
        @(negedge rd_clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge rd_clk);
            o = {tx, busy, done, rd_addr};
            check($sformatf("trace base=%h len=%0d cyc%0d", base_i, len_i, k),
                  32'(o), 32'(exp_q[k]));
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            if (k == 0) begin
                start = 1'b1; base_addr = base_i; len = len_i;
            end else if (glitch_cyc != 0 && k == glitch_cyc) begin
                start = 1'b1; base_addr = 15'h0300; len = 16'd7;
            end else begin
                start = 1'b0; base_addr = 15'($urandom); len = 16'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   dc;
        logic [14:0] rb;
        logic [15:0] rl;

        tbl[0] = '{15'h1234, 16'd0, 8'h00, 8'h00, 8'h00, 0,  15'h0000, done_at(0)};
        tbl[1] = '{15'h0010, 16'd1, 8'h55, 8'h00, 8'h00, 0,  15'h0011, done_at(1)};
        tbl[2] = '{15'h0020, 16'd3, 8'hA5, 8'h00, 8'hFF, 0,  15'h0023, done_at(3)};
        tbl[3] = '{15'h7FFF, 16'd2, 8'h11, 8'h22, 8'h00, 0,  15'h0001, done_at(2)};
        tbl[4] = '{15'h0100, 16'd2, 8'h3C, 8'hC3, 8'h00, 50, 15'h0102, done_at(2)};
        tbl[5] = '{15'h0200, 16'd0, 8'h00, 8'h00, 8'h00, 0,  15'h0102, done_at(0)};

        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);

        rd_rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        repeat (3) @(negedge rd_clk);
        check("reset tx",      32'(tx),      32'(1));
        check("reset busy",    32'(busy),    32'(0));
        check("reset done",    32'(done),    32'(0));
        check("reset rd_addr", 32'(rd_addr), 32'(0));
        rd_rst = 1'b0;
        model_addr = '0;

        for (int t = 0; t < 6; t++) begin
            mem[tbl[t].base]          = tbl[t].d0;
            mem[tbl[t].base + 15'd1] = (tbl[t].len > 1) ? tbl[t].d1 : mem[tbl[t].base + 15'd1];
            mem[tbl[t].base + 15'd2] = (tbl[t].len > 2) ? tbl[t].d2 : mem[tbl[t].base + 15'd2];
            run_xfer(tbl[t].base, tbl[t].len, tbl[t].glitch, dc);
            check($sformatf("tbl%0d end rd_addr", t), 32'(rd_addr), 32'(tbl[t].exp_end));
            check($sformatf("tbl%0d done cycle", t), 32'(dc), 32'(tbl[t].exp_done));
        end

        for (int r = 0; r < 4; r++) begin
            rb = 15'($urandom_range(0, 32767));
            rl = 16'($urandom_range(0, 3));
            run_xfer(rb, rl, 0, dc);
            check($sformatf("rand%0d done cycle", r), 32'(dc), 32'(done_at(int'(rl))));
        end

        // Reset in the middle of the data bits of 0x3C.
        mem[15'h0040] = 8'h3C;
        @(negedge rd_clk);
        start = 1'b1; base_addr = 15'h0040; len = 16'd1;
        @(negedge rd_clk);
        start = 1'b0;
        repeat (19) @(negedge rd_clk);   // cycle 20: data bit 0
        check("pre-reset tx", 32'(tx), 32'(0));
        check("pre-reset busy", 32'(busy), 32'(1));
        rd_rst = 1'b1;
        #1;
        check("mid-frame reset tx",      32'(tx),      32'(1));
        check("mid-frame reset busy",    32'(busy),    32'(0));
        check("mid-frame reset rd_addr", 32'(rd_addr), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            check($sformatf("in-reset done %0d", i), 32'({tx, busy, done}), 32'(3'b100));
        end
        rd_rst = 1'b0;
        model_addr = '0;
        run_xfer(15'h0040, 16'd1, 0, dc);
        check("post-reset done cycle", 32'(dc), 32'(done_at(1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
